// File: rtl/ps2_writer.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, shift out
// one command byte on device clock falls, then check the device ACK.
module ps2_writer #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int RTS_CYCLES     = 1000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2CLK,
    input  logic       ps2DATA,
    output logic       ps2CLK_drive,
    output logic       ps2DATA_drive,
    input  logic [7:0] txData,
    input  logic       txStart,
    output logic       busy,
    output logic       done,
    output logic [1:0] err,
    output logic       hostOwnsBus
);

    localparam int PMAX = (INHIBIT_CYCLES > RTS_CYCLES) ?
                          INHIBIT_CYCLES : RTS_CYCLES;
    localparam int PW   = $clog2(PMAX + 1);
    localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [PW-1:0] INH_LAST = PW'(INHIBIT_CYCLES - 1);
    localparam logic [PW-1:0] RTS_LAST = PW'(RTS_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ERR_OK   = 2'b00;
    localparam logic [1:0] ERR_NACK = 2'b01;
    localparam logic [1:0] ERR_TO   = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SEND,
        ACK,
        WAIT_IDLE
    } state_t;

    state_t          state, state_n;
    logic [PW-1:0]   phase, phase_n;
    logic [TW-1:0]   tout, tout_n;
    logic [3:0]      bitCnt, bitCnt_n;
    logic [9:0]      shreg, shreg_n;
    logic            clkDrv, clkDrv_n;
    logic            dataDrv, dataDrv_n;
    logic            busyR, busy_n;
    logic            doneR, done_n;
    logic [1:0]      errR, err_n;

    logic            clk_s1, clk_s2, clk_prev;
    logic            data_s1, data_s2;
    logic            clkFall;

    // Synchronizers reset to the idle (high) bus level so that the
    // release of reset never looks like a clock fall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            data_s1  <= 1'b1;
            data_s2  <= 1'b1;
        end else begin
            clk_s1   <= ps2CLK;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            data_s1  <= ps2DATA;
            data_s2  <= data_s1;
        end
    end

    assign clkFall = clk_prev & ~clk_s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            phase   <= '0;
            tout    <= '0;
            bitCnt  <= '0;
            shreg   <= '0;
            clkDrv  <= 1'b0;
            dataDrv <= 1'b0;
            busyR   <= 1'b0;
            doneR   <= 1'b0;
            errR    <= ERR_OK;
        end else begin
            state   <= state_n;
            phase   <= phase_n;
            tout    <= tout_n;
            bitCnt  <= bitCnt_n;
            shreg   <= shreg_n;
            clkDrv  <= clkDrv_n;
            dataDrv <= dataDrv_n;
            busyR   <= busy_n;
            doneR   <= done_n;
            errR    <= err_n;
        end
    end

    always_comb begin
        state_n   = state;
        phase_n   = phase;
        tout_n    = tout;
        bitCnt_n  = bitCnt;
        shreg_n   = shreg;
        clkDrv_n  = clkDrv;
        dataDrv_n = dataDrv;
        busy_n    = busyR;
        done_n    = 1'b0;
        err_n     = errR;

        unique case (state)
            IDLE: begin
                if (txStart) begin
                    shreg_n   = {1'b1, ~^txData, txData};
                    busy_n    = 1'b1;
                    err_n     = ERR_OK;
                    phase_n   = '0;
                    clkDrv_n  = 1'b1;
                    dataDrv_n = 1'b0;
                    state_n   = INHIBIT;
                end
            end

            INHIBIT: begin
                if (phase == INH_LAST) begin
                    phase_n   = '0;
                    dataDrv_n = 1'b1;
                    state_n   = RTS;
                end else begin
                    phase_n = phase + PW'(1);
                end
            end

            RTS: begin
                if (phase == RTS_LAST) begin
                    phase_n  = '0;
                    clkDrv_n = 1'b0;
                    tout_n   = '0;
                    bitCnt_n = '0;
                    state_n  = SEND;
                end else begin
                    phase_n = phase + PW'(1);
                end
            end

            SEND, ACK, WAIT_IDLE: begin
                // Timeout takes priority over any clock fall this cycle.
                if (tout == TO_LAST) begin
                    clkDrv_n  = 1'b0;
                    dataDrv_n = 1'b0;
                    err_n     = ERR_TO;
                    done_n    = 1'b1;
                    busy_n    = 1'b0;
                    state_n   = IDLE;
                end else begin
                    tout_n = tout + TW'(1);
                    if (state == SEND) begin
                        if (clkFall) begin
                            dataDrv_n = ~shreg[bitCnt];
                            bitCnt_n  = bitCnt + 4'd1;
                            if (bitCnt == 4'd9) begin
                                state_n = ACK;
                            end
                        end
                    end else if (state == ACK) begin
                        if (clkFall) begin
                            err_n   = data_s2 ? ERR_NACK : ERR_OK;
                            state_n = WAIT_IDLE;
                        end
                    end else begin
                        if (clk_s2 && data_s2) begin
                            done_n  = 1'b1;
                            busy_n  = 1'b0;
                            state_n = IDLE;
                        end
                    end
                end
            end

            default: begin
                clkDrv_n  = 1'b0;
                dataDrv_n = 1'b0;
                busy_n    = 1'b0;
                state_n   = IDLE;
            end
        endcase
    end

    assign ps2CLK_drive  = clkDrv;
    assign ps2DATA_drive = dataDrv;
    assign busy          = busyR;
    assign hostOwnsBus   = busyR;
    assign done          = doneR;
    assign err           = errR;

endmodule

// File: tb/tb_ps2_writer.sv
// Bench for ps2_writer: open-drain bus with a behavioural device that
// generates the PS/2 clock, records the frame and optionally ACKs.
module tb_ps2_writer;

    localparam int INH  = 50;
    localparam int RTSC = 20;
    localparam int TO   = 3000;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2CLK, ps2DATA;
    logic       ps2CLK_drive, ps2DATA_drive;
    logic [7:0] txData;
    logic       txStart;
    logic       busy, done, hostOwnsBus;
    logic [1:0] err;

    logic dev_clk_low  = 1'b0;
    logic dev_data_low = 1'b0;

    assign ps2CLK  = ~(ps2CLK_drive | dev_clk_low);
    assign ps2DATA = ~(ps2DATA_drive | dev_data_low);

    ps2_writer #(
        .INHIBIT_CYCLES(INH),
        .RTS_CYCLES    (RTSC),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ps2CLK       (ps2CLK),
        .ps2DATA      (ps2DATA),
        .ps2CLK_drive (ps2CLK_drive),
        .ps2DATA_drive(ps2DATA_drive),
        .txData       (txData),
        .txStart      (txStart),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .hostOwnsBus  (hostOwnsBus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int own_err  = 0;

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (hostOwnsBus !== busy) own_err++;
    end

    typedef struct {
        logic [10:0] frame;
        logic [1:0]  err;
    } exp_t;

    typedef struct {
        logic [7:0] d;
        logic       par;
        bit         ack;
        logic [1:0] err;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[4];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send_start(input logic [7:0] d, input logic par,
                              input logic [1:0] e, input bit push);
        @(negedge clk);
        txData  = d;
        txStart = 1'b1;
        @(negedge clk);
        txStart = 1'b0;
        txData  = 8'h00;
        chk("busy_on_accept", busy, 1);
        chk("err_cleared_on_accept", err, 0);
        if (push) sb.push_back('{{1'b1, par, d, 1'b0}, e});
    endtask

    task automatic dev_run(input bit ack, input int nclk,
                           input int poke_at, output logic [10:0] got,
                           output int inh, output int rts);
        int guard;
        got   = '0;
        inh   = 0;
        rts   = 0;
        guard = 0;
        forever begin
            if (ps2CLK_drive && !ps2DATA_drive) inh++;
            else if (ps2CLK_drive && ps2DATA_drive) rts++;
            else if (ps2DATA_drive) break;
            if (guard == 5000) break;
            guard++;
            @(negedge clk);
        end
        chk("rts_release_seen", guard < 5000, 1);
        repeat (5) @(negedge clk);
        for (int i = 0; i < nclk; i++) begin
            repeat (HALF) @(negedge clk);
            got[i] = ps2DATA;
            if (i == poke_at) begin
                txData  = 8'h55;
                txStart = 1'b1;
                @(negedge clk);
                txStart = 1'b0;
                txData  = 8'h00;
            end
            if (i == 10 && ack) dev_data_low = 1'b1;
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            chk("clk_not_driven_in_send", ps2CLK_drive, 0);
            dev_clk_low = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        dev_data_low = 1'b0;
    endtask

    task automatic wait_done(input int base, input logic [10:0] got,
                             input bit chk_frame);
        int   g;
        exp_t e;
        g = 0;
        while (done_cnt == base && g < TO + 100) begin
            @(negedge clk);
            g++;
        end
        chk("done_seen", done_cnt != base, 1);
        repeat (3) @(negedge clk);
        chk("single_done", done_cnt, base + 1);
        chk("busy_after_done", busy, 0);
        chk("clk_drive_after", ps2CLK_drive, 0);
        chk("data_drive_after", ps2DATA_drive, 0);
        if (sb.size() == 0) begin
            chk("scoreboard_entry", 0, 1);
        end else begin
            e = sb.pop_front();
            chk("err_code", err, e.err);
            if (chk_frame) chk("frame", got, e.frame);
        end
    endtask

    initial begin
        logic [10:0] got;
        int inh, rts, base, n;
        exp_t e;

        vecs[0] = '{8'hED, 1'b1, 1'b1, 2'b00};
        vecs[1] = '{8'hF4, 1'b0, 1'b0, 2'b01};
        vecs[2] = '{8'hFF, 1'b1, 1'b1, 2'b00};
        vecs[3] = '{8'h00, 1'b1, 1'b1, 2'b00};

        rst     = 1'b1;
        txStart = 1'b0;
        txData  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_clk_drive", ps2CLK_drive, 0);
        chk("rst_data_drive", ps2DATA_drive, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_own", hostOwnsBus, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_busy", busy, 0);

        // Normal ACK, NACK, and back-to-back transfers.
        for (int i = 0; i < 4; i++) begin
            base = done_cnt;
            send_start(vecs[i].d, vecs[i].par, vecs[i].err, 1);
            dev_run(vecs[i].ack, 11, -1, got, inh, rts);
            chk("inhibit_len", inh, INH);
            chk("rts_len", rts, RTSC);
            wait_done(base, got, 1);
        end

        // txStart during a transfer must be ignored.
        base = done_cnt;
        send_start(8'hED, 1'b1, 2'b00, 1);
        dev_run(1'b1, 11, 3, got, inh, rts);
        wait_done(base, got, 1);
        repeat (20) @(negedge clk);
        chk("no_second_start", busy, 0);

        // Device never clocks: timeout.
        base = done_cnt;
        send_start(8'hED, 1'b1, 2'b10, 1);
        n = 0;
        while (!(ps2DATA_drive && !ps2CLK_drive) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("to_release_seen", n < 5000, 1);
        n = 0;
        while (done !== 1'b1 && n < TO + 50) begin
            @(negedge clk);
            n++;
        end
        chk("to_latency", (n >= TO) && (n <= TO + 3), 1);
        chk("to_err", err, 2'b10);
        chk("to_clk_drive", ps2CLK_drive, 0);
        chk("to_data_drive", ps2DATA_drive, 0);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("to_sb_err", err, e.err);
        end else begin
            chk("to_scoreboard_entry", 0, 1);
        end
        repeat (5) @(negedge clk);

        // Asynchronous reset mid-frame aborts without a done pulse.
        base = done_cnt;
        send_start(8'hED, 1'b1, 2'b00, 0);
        dev_run(1'b1, 5, -1, got, inh, rts);
        chk("pre_rst_busy", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_clk_drive", ps2CLK_drive, 0);
        chk("async_rst_data_drive", ps2DATA_drive, 0);
        chk("async_rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("no_done_on_abort", done_cnt, base);

        base = done_cnt;
        send_start(8'hF4, 1'b0, 2'b00, 1);
        dev_run(1'b1, 11, -1, got, inh, rts);
        wait_done(base, got, 1);

        chk("own_tracks_busy", own_err, 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_writer.md
Name: ps2_writer

Overview:
- Host-to-device PS/2 transmitter. Sends one command byte, such as 0xED (LEDs) or 0xF4 (enable), to a keyboard or mouse over the open-drain CLK/DATA pair.
- Runs synchronously on system clk: samples the device clock through synchronizers, generates the inhibit and request-to-send timing, shifts out bits and checks the device ACK.
- Asserts hostOwnsBus while active so the receive path can be held off.

Parameters:
- INHIBIT_CYCLES, 5000, clk cycles CLK is held low before request-to-send (100 us at 50 MHz).
- RTS_CYCLES, 1000, clk cycles DATA is held low with CLK still low before CLK is released (20 us).
- TIMEOUT_CYCLES, 750000, max clk cycles from CLK release to ACK completion (15 ms).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- ps2CLK  in  1  raw PS/2 clock line (asynchronous)
- ps2DATA  in  1  raw PS/2 data line (asynchronous)
- ps2CLK_drive  out  1  1 = pull CLK low; 0 = release (high-Z)
- ps2DATA_drive  out  1  1 = pull DATA low; 0 = release
- txData  in  8  byte to send, captured when txStart is accepted
- txStart  in  1  1-cycle request; accepted only in IDLE
- busy  out  1  high from acceptance until done
- done  out  1  1-cycle pulse at end of transaction; err valid in the same cycle
- err  out  2  00 ok, 01 no ACK, 10 timeout; held until next accepted txStart
- hostOwnsBus  out  1  equals busy; gates the receiver

Behaviour:
- Reset values:
  - All outputs 0; state IDLE; lines released.
  - Reset asserted mid-transfer releases both lines immediately (asynchronous) and aborts with no done pulse.
- Input sampling:
  - ps2CLK and ps2DATA pass through 2-flop synchronizers.
  - clkFall = previous synced CLK high and current synced CLK low; one-cycle strobe.
- Register contents:
  - Shift register = {stop=1, parity, txData[7:0]}, loaded on acceptance.
  - parity = ~^txData (odd parity).
  - 4-bit bitCnt.
- State machine:
  - IDLE:
    - txStart → latch data, busy=1, err=00, go to INHIBIT.
    - txStart while not IDLE is ignored (no latch, no effect).
  - INHIBIT: ps2CLK_drive=1 for INHIBIT_CYCLES, then RTS.
  - RTS:
    - ps2CLK_drive=1 and ps2DATA_drive=1 (start bit 0) for RTS_CYCLES.
    - Then release CLK (drive=0), keep DATA low, clear the timeout counter and bitCnt, go to SEND.
  - SEND:
    - On each clkFall with bitCnt 0..9: drive bit bitCnt of the shift register (LSB first) as ps2DATA_drive = ~bit, then bitCnt++.
    - Falls 1-8 carry D0-D7, fall 9 carries parity, fall 10 carries stop (release DATA).
    - After the stop bit is placed, go to ACK.
  - ACK:
    - On the next clkFall (11th), sample synced DATA.
    - DATA 0 → err=00; DATA 1 → err=01. Go to WAIT_IDLE.
  - WAIT_IDLE:
    - Wait until synced CLK=1 and DATA=1.
    - Then done=1 for one cycle, busy=0, go to IDLE.
- Timeout:
  - The counter runs in SEND, ACK and WAIT_IDLE.
  - Reaching TIMEOUT_CYCLES → release both lines, err=10, done pulse, IDLE.
  - If the timeout and an ACK fall occur in the same cycle, the timeout wins.
- Line discipline: ps2DATA_drive changes only in the cycle after a detected clkFall, or at RTS entry and exit. CLK is never driven outside INHIBIT and RTS.
- Width rules:
  - Timer counters are sized to their parameter with clog2.
  - bitCnt never exceeds 10; overflow is impossible by construction.

Test Plan:
1. txData=0xED, device model clocks at 12.5 kHz and ACKs. Required response:
   - CLK low ≥ INHIBIT_CYCLES, then DATA low RTS_CYCLES before CLK release.
   - Device samples 0,1,0,1,1,0,1,1,1, parity 1, stop 1.
   - done pulse with err=00; busy low afterwards.
2. txData=0xF4 (five ones), device holds DATA high on the 11th clock → parity bit sampled 0, done with err=01.
3. Device never clocks after CLK release → done exactly TIMEOUT_CYCLES (+ sync latency ≤3) after release, err=10, both drives 0.
4. txStart pulsed again with txData=0x55 during the transfer of 0xED → ignored; the device receives 0xED only; a single done pulse.
5. rst asserted after the 4th data bit → ps2CLK_drive and ps2DATA_drive fall to 0 without waiting for a clk edge; busy=0, no done pulse. A subsequent txStart of 0xF4 completes normally with err=00.
6. Two back-to-back transfers, 0xFF then 0x00 (parity bits 1 then 1) → both complete with err=00. err is cleared at the second acceptance, and hostOwnsBus tracks busy throughout.
